// File: rtl/sample_frame_decoder.sv
// Frame decoder: finds 48-bit sync, tracks lock, and emits the ADC, audio and sequence fields of a 512-word frame.
// Define SEQ_CHECK_EN to add sequence-consistency checking on seqError; otherwise seqError is tied to 0.
module sample_frame_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dataIn,
  input  logic        dataInValid,
  output logic [9:0]  adcData,
  output logic        adcDataValid,
  output logic [11:0] audioLeft,
  output logic [11:0] audioRight,
  output logic        audioValid,
  output logic [5:0]  sequenceNumber,
  output logic        sequenceValid,
  output logic        locked,
  output logic        seqError
);

  localparam logic [1:0]  ST_SEARCH = 2'd0;
  localparam logic [1:0]  ST_VERIFY = 2'd1;
  localparam logic [1:0]  ST_LOCKED = 2'd2;
  localparam logic [47:0] SYNC      = 48'hDEAD_BEEF_CAFE;

  logic [1:0]  state_q, state_d;
  logic [8:0]  pos_q, pos_d;
  logic [47:0] sr_q, sr_d;
  logic        bad_cnt_q, bad_cnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic        frame_ok_q, frame_ok_d;
  logic [5:0]  lhi_q, lhi_d, llo_q, llo_d, rhi_q, rhi_d;
  logic [9:0]  adc_q, adc_d;
  logic        adc_vld_q, adc_vld_d;
  logic [11:0] left_q, left_d, right_q, right_d;
  logic        aud_vld_q, aud_vld_d;
  logic [5:0]  seq_q, seq_d;
  logic        seq_vld_q, seq_vld_d;
  logic        locked_q, locked_d;

  logic [5:0]  field;
  logic [5:0]  sync_chunk;
  logic [47:0] window;
  logic        in_sync;
  logic        chunk_ok;
  logic        bad_now;

  assign field      = dataIn[15:10];
  assign sync_chunk = SYNC[6*pos_q[2:0] +: 6];
  // Newest field enters at the top, so after eight words the first-sent chunk sits in [5:0].
  assign window     = {field, sr_q[47:6]};
  assign in_sync    = (pos_q[8:3] == 6'd0);
  assign chunk_ok   = (field == sync_chunk);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    sr_d        = sr_q;
    bad_cnt_d   = bad_cnt_q;
    frame_bad_d = frame_bad_q;
    frame_ok_d  = frame_ok_q;
    lhi_d       = lhi_q;
    llo_d       = llo_q;
    rhi_d       = rhi_q;
    adc_d       = adc_q;
    adc_vld_d   = 1'b0;
    left_d      = left_q;
    right_d     = right_q;
    aud_vld_d   = 1'b0;
    seq_d       = seq_q;
    seq_vld_d   = 1'b0;
    bad_now     = 1'b0;

    if (dataInValid) begin
      adc_d     = dataIn[9:0];
      adc_vld_d = 1'b1;
      case (state_q)
        ST_SEARCH: begin
          sr_d = window;
          if (window == SYNC) begin
            state_d = ST_VERIFY;
            pos_d   = 9'd8;
          end
        end
        ST_VERIFY: begin
          pos_d = pos_q + 9'd1;
          if (in_sync) begin
            if (!chunk_ok) begin
              state_d = ST_SEARCH;
              pos_d   = 9'd0;
              sr_d    = '0;
            end else if (pos_q == 9'd7) begin
              state_d     = ST_LOCKED;
              frame_ok_d  = 1'b1;
              frame_bad_d = 1'b0;
              bad_cnt_d   = 1'b0;
            end
          end
        end
        ST_LOCKED: begin
          pos_d = pos_q + 9'd1;
          if (in_sync) begin
            bad_now     = ((pos_q != 9'd0) && frame_bad_q) || !chunk_ok;
            frame_bad_d = bad_now;
            if (pos_q == 9'd7) begin
              frame_ok_d = !bad_now;
              if (!bad_now) begin
                bad_cnt_d = 1'b0;
              end else if (bad_cnt_q) begin
                state_d   = ST_SEARCH;
                pos_d     = 9'd0;
                sr_d      = '0;
                bad_cnt_d = 1'b0;
              end else begin
                bad_cnt_d = 1'b1;
              end
            end
          end
          case (pos_q)
            9'd8:  lhi_d = field;
            9'd9:  llo_d = field;
            9'd10: rhi_d = field;
            9'd11: if (frame_ok_q) begin
              left_d    = {lhi_q, llo_q};
              right_d   = {rhi_q, field};
              aud_vld_d = 1'b1;
            end
            9'd14: if (frame_ok_q) begin
              seq_d     = field;
              seq_vld_d = 1'b1;
            end
            default: ;
          endcase
        end
        default: begin
          state_d = ST_SEARCH;
          pos_d   = 9'd0;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      pos_q       <= '0;
      sr_q        <= '0;
      bad_cnt_q   <= 1'b0;
      frame_bad_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      lhi_q       <= '0;
      llo_q       <= '0;
      rhi_q       <= '0;
      adc_q       <= '0;
      adc_vld_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      aud_vld_q   <= 1'b0;
      seq_q       <= '0;
      seq_vld_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      sr_q        <= sr_d;
      bad_cnt_q   <= bad_cnt_d;
      frame_bad_q <= frame_bad_d;
      frame_ok_q  <= frame_ok_d;
      lhi_q       <= lhi_d;
      llo_q       <= llo_d;
      rhi_q       <= rhi_d;
      adc_q       <= adc_d;
      adc_vld_q   <= adc_vld_d;
      left_q      <= left_d;
      right_q     <= right_d;
      aud_vld_q   <= aud_vld_d;
      seq_q       <= seq_d;
      seq_vld_q   <= seq_vld_d;
      locked_q    <= locked_d;
    end
  end

`ifdef SEQ_CHECK_EN
  logic [5:0] seq_cur_q, seq_cur_d;
  logic [5:0] prev_seq_q, prev_seq_d;
  logic       have_prev_q, have_prev_d;
  logic       err_done_q, err_done_d;
  logic       seq_err_q, seq_err_d;
  logic       fault;
  logic [5:0] prev_succ;

  // Sequence numbers count modulo 63, so 62 rolls over to 0.
  assign prev_succ = (prev_seq_q >= 6'd62) ? 6'd0 : prev_seq_q + 6'd1;

  always_comb begin
    seq_cur_d   = seq_cur_q;
    prev_seq_d  = prev_seq_q;
    have_prev_d = have_prev_q;
    err_done_d  = err_done_q;
    seq_err_d   = 1'b0;
    fault       = 1'b0;
    if (dataInValid && (state_q == ST_LOCKED)) begin
      if (pos_q == 9'd0) begin
        err_done_d = 1'b0;
      end else if (pos_q == 9'd14) begin
        seq_cur_d   = field;
        prev_seq_d  = field;
        have_prev_d = 1'b1;
        fault       = have_prev_q && (field != prev_seq_q) && (field != prev_succ);
      end else if (pos_q > 9'd14) begin
        fault = (field != seq_cur_q);
      end
      if (fault && !err_done_q) begin
        seq_err_d  = 1'b1;
        err_done_d = 1'b1;
      end
    end
    if (state_d != ST_LOCKED) begin
      have_prev_d = 1'b0;
      err_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq_cur_q   <= '0;
      prev_seq_q  <= '0;
      have_prev_q <= 1'b0;
      err_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      seq_cur_q   <= seq_cur_d;
      prev_seq_q  <= prev_seq_d;
      have_prev_q <= have_prev_d;
      err_done_q  <= err_done_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign seqError = seq_err_q;
`else
  assign seqError = 1'b0;
`endif

  assign adcData        = adc_q;
  assign adcDataValid   = adc_vld_q;
  assign audioLeft      = left_q;
  assign audioRight     = right_q;
  assign audioValid     = aud_vld_q;
  assign sequenceNumber = seq_q;
  assign sequenceValid  = seq_vld_q;
  assign locked         = locked_q;

endmodule

// File: tb/tb_sample_frame_decoder.sv
// Scoreboard bench for sample_frame_decoder: expected ADC/audio/sequence results are queued as words are driven.
module tb_sample_frame_decoder;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dataIn;
  logic        dataInValid;
  logic [9:0]  adcData;
  logic        adcDataValid;
  logic [11:0] audioLeft, audioRight;
  logic        audioValid;
  logic [5:0]  sequenceNumber;
  logic        sequenceValid;
  logic        locked;
  logic        seqError;

`ifdef SEQ_CHECK_EN
  localparam int SEQ_ON = 1;
`else
  localparam int SEQ_ON = 0;
`endif

  sample_frame_decoder dut (
    .clock(clock), .reset(reset), .dataIn(dataIn), .dataInValid(dataInValid),
    .adcData(adcData), .adcDataValid(adcDataValid),
    .audioLeft(audioLeft), .audioRight(audioRight), .audioValid(audioValid),
    .sequenceNumber(sequenceNumber), .sequenceValid(sequenceValid),
    .locked(locked), .seqError(seqError)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int err_seen = 0;
  int err_exp = 0;
  int word_cnt = 0;
  logic [9:0]  adc_q[$];
  logic [23:0] aud_q[$];
  logic [5:0]  seq_q[$];
  logic [5:0]  sync_tab [8] = '{6'h3E, 6'h2B, 6'h3C, 6'h3B, 6'h3E, 6'h36, 6'h2A, 6'h37};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (adcDataValid) begin
        if (adc_q.size() == 0) check_val("adc_extra", 32'(adcDataValid), 32'd0);
        else check_val("adc", 32'(adcData), 32'(adc_q.pop_front()));
      end
      if (audioValid) begin
        if (aud_q.size() == 0) check_val("audio_extra", 32'(audioValid), 32'd0);
        else check_val("audio", 32'({audioLeft, audioRight}), 32'(aud_q.pop_front()));
      end
      if (sequenceValid) begin
        if (seq_q.size() == 0) check_val("seq_extra", 32'(sequenceValid), 32'd0);
        else check_val("seq", 32'(sequenceNumber), 32'(seq_q.pop_front()));
      end
      if (seqError) err_seen++;
    end
  end

  task automatic put(input logic [5:0] f, input bit gaps);
    logic [9:0] s;
    s = 10'($urandom);
    dataIn = {f, s};
    dataInValid = 1'b1;
    adc_q.push_back(s);
    @(posedge clock); #1;
    dataInValid = 1'b0;
    dataIn = 16'($urandom);
    if (gaps) begin
      word_cnt++;
      if (word_cnt % 10 == 0) repeat (3) begin @(posedge clock); #1; end
    end
  endtask

  task automatic send_frame(input int from_pos, input int to_pos, input logic [5:0] sq,
                            input logic [11:0] l, input logic [11:0] r, input int bad_chunk,
                            input bit exp_aud, input bit exp_seq, input bit lk_pre,
                            input bit lk_post, input bit gaps);
    logic [5:0] f;
    for (int p = from_pos; p <= to_pos; p++) begin
      if (p < 8)        f = sync_tab[p] ^ ((p == bad_chunk) ? 6'h01 : 6'h00);
      else if (p == 8)  f = l[11:6];
      else if (p == 9)  f = l[5:0];
      else if (p == 10) f = r[11:6];
      else if (p == 11) f = r[5:0];
      else if (p < 14)  f = 6'h15;
      else              f = sq;
      if (p == 7) check_val("locked_pre", 32'(locked), 32'(lk_pre));
      if (p == 11 && exp_aud) aud_q.push_back({l, r});
      if (p == 14 && exp_seq) seq_q.push_back(sq);
      put(f, gaps);
      if (p == 7) check_val("locked_post", 32'(locked), 32'(lk_post));
    end
  endtask

  task automatic drain;
    repeat (3) begin @(posedge clock); #1; end
    check_val("adc_pending", 32'(adc_q.size()), 32'd0);
    check_val("audio_pending", 32'(aud_q.size()), 32'd0);
    check_val("seq_pending", 32'(seq_q.size()), 32'd0);
    check_val("seqerr_count", 32'(err_seen), 32'(err_exp));
  endtask

  task automatic do_reset;
    reset = 1'b1;
    dataInValid = 1'b0;
    #7;
    check_val("rst_locked", 32'(locked), 32'd0);
    check_val("rst_pulses", 32'({adcDataValid, audioValid, sequenceValid, seqError}), 32'd0);
    check_val("rst_adc", 32'(adcData), 32'd0);
    check_val("rst_audio", 32'({audioLeft, audioRight}), 32'd0);
    check_val("rst_seqnum", 32'(sequenceNumber), 32'd0);
    adc_q.delete();
    aud_q.delete();
    seq_q.delete();
    err_seen = 0;
    err_exp = 0;
    word_cnt = 0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dataIn = '0;
    dataInValid = 1'b0;
    #2;
    do_reset();

    // Aligned stream: lock on frame 1 pos 7, then audio/sequence per frame.
    send_frame(0, 511, 6'd0, 12'hABC, 12'h123, -1, 0, 0, 0, 0, 0);
    send_frame(0, 511, 6'd1, 12'hABC, 12'h123, -1, 1, 1, 0, 1, 0);
    send_frame(0, 511, 6'd2, 12'h5A5, 12'h0F0, -1, 1, 1, 1, 1, 0);
    // Single bad frame keeps lock; two in a row drop it, then relock.
    send_frame(0, 511, 6'd3, 12'h111, 12'h222, 3, 0, 0, 1, 1, 0);
    send_frame(0, 511, 6'd4, 12'h321, 12'hFED, -1, 1, 1, 1, 1, 0);
    send_frame(0, 511, 6'd5, 12'h333, 12'h444, 0, 0, 0, 1, 1, 0);
    send_frame(0, 511, 6'd6, 12'h555, 12'h666, 7, 0, 0, 1, 0, 0);
    send_frame(0, 511, 6'd7, 12'h777, 12'h888, -1, 0, 0, 0, 0, 0);
    send_frame(0, 511, 6'd8, 12'h9AB, 12'hCDE, -1, 1, 1, 0, 1, 0);
    drain();

    // Reset in the middle of a frame: its remaining words must produce nothing.
    send_frame(0, 10, 6'd9, 12'hF0F, 12'h0F0, -1, 0, 0, 1, 1, 0);
    drain();
    do_reset();
    send_frame(11, 511, 6'd9, 12'hF0F, 12'h0F0, -1, 0, 0, 0, 0, 0);
    drain();

    // Stream joined at offset 100; sequence jumps 3 -> 5 once locked.
    do_reset();
    send_frame(100, 511, 6'd3, 12'h000, 12'h000, -1, 0, 0, 0, 0, 0);
    send_frame(0, 511, 6'd3, 12'h246, 12'h135, -1, 0, 0, 0, 0, 0);
    send_frame(0, 511, 6'd3, 12'h7E1, 12'h81F, -1, 1, 1, 0, 1, 0);
    err_exp += SEQ_ON;
    send_frame(0, 511, 6'd5, 12'hC3C, 12'h3C3, -1, 1, 1, 1, 1, 0);
    drain();

    // Gapped stream decodes the same; sequence 62 -> 0 is legal.
    do_reset();
    send_frame(0, 511, 6'd60, 12'hABC, 12'h123, -1, 0, 0, 0, 0, 1);
    send_frame(0, 511, 6'd61, 12'hABC, 12'h123, -1, 1, 1, 0, 1, 1);
    send_frame(0, 511, 6'd62, 12'h5A5, 12'h0F0, -1, 1, 1, 1, 1, 1);
    send_frame(0, 511, 6'd0, 12'h6B7, 12'h8C9, -1, 1, 1, 1, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sample_frame_decoder.md
SAMPLE_FRAME_DECODER -- requirements
Module: sample_frame_decoder

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: dataIn  input  16  captured word; [15:10] side-channel field, [9:0] sample.
REQ-004 SHALL have port: dataInValid  input  1  dataIn qualifier; a word is accepted only on cycles where this is high.
REQ-005 SHALL have port: adcData  output  10  sample field of last accepted word.
REQ-006 SHALL have port: adcDataValid  output  1  one-cycle pulse per accepted word.
REQ-007 SHALL have ports: audioLeft, audioRight  output  12 each  decoded audio sample pair.
REQ-008 SHALL have port: audioValid  output  1  one-cycle pulse when audioLeft/audioRight update.
REQ-009 SHALL have port: sequenceNumber  output  6  sequence field of current frame.
REQ-010 SHALL have port: sequenceValid  output  1  one-cycle pulse when sequenceNumber updates.
REQ-011 SHALL have port: locked  output  1  frame alignment held.
REQ-012 SHALL have port: seqError  output  1  one-cycle pulse on sequence fault.

Function
REQ-013 Frame SHALL be 512 accepted words, positions 0-511; the position counter SHALL advance only on accepted words and wrap 511->0.
REQ-014 Sync field at positions 0-7 SHALL be 0x3E,0x2B,0x3C,0x3B,0x3E,0x36,0x2A,0x37 (6-bit chunks of 0xDEADBEEFCAFE, LSB chunk first).
REQ-015 Field map: pos 8 = left[11:6], 9 = left[5:0], 10 = right[11:6], 11 = right[5:0], 12-13 = CRC (ignored), 14-511 = sequence number.
REQ-016 adcData/adcDataValid SHALL follow every accepted word with 1-cycle latency, regardless of lock state.
REQ-017 States: SEARCH, VERIFY, LOCKED.
REQ-018 SEARCH: 8-entry shift register of accepted fields; on an 8-word sync match -> VERIFY, with the next accepted word taken as position 8.
REQ-019 VERIFY: positions 0-7 of the next frame are compared; all match -> LOCKED on acceptance of position 7; any mismatch -> SEARCH immediately, shift register cleared.
REQ-020 LOCKED: any sync chunk mismatch marks the frame bad; a good frame clears the bad-frame count; second consecutive bad frame -> SEARCH on acceptance of position 7.
REQ-021 locked SHALL be high exactly while state is LOCKED, registered.
REQ-022 audioValid SHALL pulse 1 cycle after position 11 is accepted, only in LOCKED and only if the current frame's sync matched; audioLeft/audioRight otherwise hold.
REQ-023 sequenceNumber SHALL load from position 14 with sequenceValid pulsing 1 cycle later, under the same conditions as REQ-022.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; no partial audio or sequence update is emitted.

Reset
REQ-025 On reset: state SEARCH, position 0, shift register 0, bad-frame count 0, every output 0.

Configuration
REQ-026 Macro SEQ_CHECK_EN defined: seqError SHALL pulse (LOCKED only) when any of positions 15-511 differs from position 14, or when a frame's sequence is neither the previous frame's value nor its successor modulo 63 (62->0); at most one pulse per frame.
REQ-027 SEQ_CHECK_EN undefined: seqError SHALL be constant 0 and no comparison logic synthesised.

Verification
REQ-028 Reset, stream from position 0, seq 0 -> locked rises 1 cycle after word 519 (frame 1 pos 7); adcData tracks sample field at 1-cycle latency throughout.
REQ-029 Locked, frame carries left 0xABC, right 0x123 -> audioValid single pulse with audioLeft=0xABC, audioRight=0x123.
REQ-030 Stream started at offset 100 into a frame -> lock at correct alignment; first audioValid in frame following lock.
REQ-031 One corrupted sync chunk -> locked stays high, that frame's audioValid suppressed; two consecutive corrupted frames -> locked falls after second frame's pos 7.
REQ-032 dataInValid low for 3-cycle gaps every 10 words -> identical decode to gapless stream.
REQ-033 SEQ_CHECK_EN: sequence 3 then 5 -> one seqError pulse; sequence 62 then 0 -> none; without macro -> seqError stays 0.
